// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: owns the PC and fetches one instruction at a time.
// Holds the fetched word under stall and drops stale responses on redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    OUT,
    DROP
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic [31:0] instr_pc_d;
  logic        valid_d;
  logic        accept;
  logic [31:0] target;

  assign imem_req  = (state_q == FETCH);
  assign imem_addr = pc_q;
  assign accept    = imem_req & imem_ready;
  assign target    = redirect_pc & ~32'h3;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr;
    instr_pc_d = instr_pc;
    valid_d    = instr_valid;
    unique case (state_q)
      FETCH: begin
        if (redirect) begin
          pc_d    = target;
          state_d = accept ? DROP : FETCH;
        end else if (accept) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          pc_d    = target;
          state_d = imem_rvalid ? FETCH : DROP;
        end else if (imem_rvalid) begin
          instr_d    = imem_rdata;
          instr_pc_d = pc_q;
          valid_d    = 1'b1;
          pc_d       = pc_q + PC_STEP;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (redirect) begin
          valid_d = 1'b0;
          pc_d    = target;
          state_d = FETCH;
        end else if (!stall) begin
          valid_d = 1'b0;
          state_d = FETCH;
        end
      end
      DROP: begin
        // Response belongs to an abandoned fetch; only its arrival matters.
        if (redirect) begin
          pc_d = target;
        end
        if (imem_rvalid) begin
          state_d = FETCH;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= FETCH;
      pc_q        <= RESET_PC;
      instr_valid <= 1'b0;
      instr       <= NOP;
      instr_pc    <= RESET_PC;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      instr_valid <= valid_d;
      instr       <= instr_d;
      instr_pc    <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed and random checks of the fetch unit
// against a flag-level model and a single-outstanding memory model.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] STEP = 32'd4;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_ready;
  logic        w_rvalid;
  logic [31:0] w_rdata;
  logic        w_red;
  logic [31:0] w_rpc;
  logic        w_stall;
  logic        w_valid;
  logic [31:0] w_instr;
  logic [31:0] w_ipc;

  int n_chk;
  int n_err;

  // memory model
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          mem_cnt;
  int          lat;
  int          n_resp;

  // fetch-unit model
  logic [31:0] m_pc;
  logic        m_out;
  logic        m_stale;
  logic [31:0] m_fa;
  logic        m_hold;
  logic [31:0] m_instr;
  logic [31:0] m_ipc;

  instr_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .stall(stall), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(w_ready), .imem_rvalid(w_rvalid),
    .imem_rdata(w_rdata),
    .redirect(w_red), .redirect_pc(w_rpc),
    .stall(w_stall), .instr_valid(w_valid),
    .instr(w_instr), .instr_pc(w_ipc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  // Advance one clock; model and memory consume inputs captured pre-edge.
  task automatic tick();
    logic s_rst, s_red, s_stall, s_ready, s_rvalid, s_dreq, mreq;
    logic [31:0] s_rpc, s_daddr, tgt;
    s_rst    = rst_n;
    s_red    = redirect;
    s_rpc    = redirect_pc;
    s_stall  = stall;
    s_ready  = imem_ready;
    s_rvalid = imem_rvalid;
    s_dreq   = imem_req;
    s_daddr  = imem_addr;
    mreq     = !m_out && !m_hold;
    tgt      = s_rpc & ~32'h3;
    @(posedge clk);
    if (!s_rst) begin
      m_pc = 32'h0; m_out = 0; m_stale = 0; m_hold = 0;
      m_instr = NOP; m_ipc = 32'h0; mem_busy = 0;
    end else begin
      if (m_hold) begin
        if (s_red) begin m_hold = 0; m_pc = tgt; end
        else if (!s_stall) m_hold = 0;
      end else if (m_out) begin
        if (s_rvalid) begin
          m_out = 0;
          if (!m_stale && !s_red) begin
            m_hold = 1; m_instr = word(m_fa);
            m_ipc = m_fa; m_pc = m_fa + STEP;
          end
        end else if (s_red) m_stale = 1;
        if (s_red) m_pc = tgt;
      end else if (mreq) begin
        if (s_ready) begin m_out = 1; m_fa = m_pc; m_stale = s_red; end
        if (s_red) m_pc = tgt;
      end
      if (s_rvalid) begin mem_busy = 0; n_resp++; end
      else if (mem_busy && mem_cnt > 0) mem_cnt--;
      if (s_dreq && s_ready) begin
        mem_busy = 1; mem_addr = s_daddr; mem_cnt = lat - 1;
      end
    end
    #1;
    imem_rvalid = mem_busy && mem_cnt == 0;
    imem_rdata  = imem_rvalid ? word(mem_addr) : $urandom;
  endtask

  task automatic go_fetch();
    stall = 0; redirect = 0; imem_ready = 0;
    for (int i = 0; i < 16 && (m_out || m_hold); i++) tick();
    if (m_out || m_hold) begin
      n_err++;
      $display("FAIL go_fetch: timeout waiting for idle fetch");
    end
  endtask

  task automatic test_reset();
    rst_n = 0; imem_ready = 0;
    tick(); tick();
    n_chk++;
    if (instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 32'h0) begin
      n_err++;
      $display("FAIL reset_out: v=%b instr=%h pc=%h want 0 %h 0",
               instr_valid, instr, instr_pc, NOP);
    end
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL reset_req: req=%b addr=%h want 1 0", imem_req, imem_addr);
    end
    n_chk++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL reset_wrap: req=%b addr=%h want 1 fffffffc", w_req, w_addr);
    end
    rst_n = 1;
  endtask

  task automatic test_sequential();
    int nv;
    logic er;
    nv = 0; lat = 1; imem_ready = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      er = !m_out && !m_hold;
      n_chk++;
      if (imem_req !== er || (er && imem_addr !== m_pc) ||
          instr_valid !== m_hold ||
          (m_hold && (instr !== m_instr || instr_pc !== m_ipc))) begin
        n_err++;
        $display("FAIL seq[%0d]: req=%b addr=%h v=%b pc=%h want %b %h %b %h",
                 i, imem_req, imem_addr, instr_valid, instr_pc,
                 er, m_pc, m_hold, m_ipc);
      end
      if (instr_valid) begin
        n_chk++;
        if (instr_pc !== 32'(nv * 4) || instr !== word(32'(nv * 4))) begin
          n_err++;
          $display("FAIL seq_pc: pc=%h instr=%h want %h %h",
                   instr_pc, instr, nv * 4, word(32'(nv * 4)));
        end
        nv++;
      end
    end
    n_chk++;
    if (nv != 10) begin
      n_err++;
      $display("FAIL seq_count: pulses=%0d want 10", nv);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] a0;
    go_fetch();
    a0 = m_pc;
    repeat (3) begin
      tick();
      n_chk++;
      if (imem_req !== 1'b1 || imem_addr !== a0) begin
        n_err++;
        $display("FAIL bp_hold_req: req=%b addr=%h want 1 %h", imem_req, imem_addr, a0);
      end
    end
    lat = 1; imem_ready = 1;
    tick();
    imem_ready = 0;
    tick();
    stall = 1;
    repeat (4) begin
      tick();
      n_chk++;
      if (instr_valid !== 1'b1 || instr !== word(a0) ||
          instr_pc !== a0 || imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL bp_stall: v=%b instr=%h pc=%h req=%b want 1 %h %h 0",
                 instr_valid, instr, instr_pc, imem_req, word(a0), a0);
      end
    end
    stall = 0;
    tick();
    n_chk++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== a0 + 4) begin
      n_err++;
      $display("FAIL bp_release: v=%b req=%b addr=%h want 0 1 %h",
               instr_valid, imem_req, imem_addr, a0 + 4);
    end
  endtask

  task automatic test_redirect_wait();
    go_fetch();
    lat = 3; imem_ready = 1;
    tick();
    imem_ready = 0; redirect = 1; redirect_pc = 32'h0000_0104;
    tick();
    redirect = 0;
    for (int i = 0; i < 10 && (m_out || m_hold); i++) begin
      n_chk++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL rw_drop: v=%b req=%b want 0 0", instr_valid, imem_req);
      end
      tick();
    end
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h104 || instr_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rw_addr: req=%b addr=%h v=%b want 1 104 0",
               imem_req, imem_addr, instr_valid);
    end
    lat = 1; imem_ready = 1;
    tick();
    imem_ready = 0;
    tick();
    n_chk++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h104 || instr !== word(32'h104)) begin
      n_err++;
      $display("FAIL rw_instr: v=%b pc=%h instr=%h want 1 104 %h",
               instr_valid, instr_pc, instr, word(32'h104));
    end
  endtask

  task automatic test_redirect_rvalid();
    go_fetch();
    lat = 1; imem_ready = 1;
    tick();
    imem_ready = 0; redirect = 1; redirect_pc = 32'h0000_0300;
    tick();
    redirect = 0;
    n_chk++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin
      n_err++;
      $display("FAIL rr_drop: v=%b req=%b addr=%h want 0 1 300",
               instr_valid, imem_req, imem_addr);
    end
    imem_ready = 1;
    tick();
    imem_ready = 0;
    tick();
    n_chk++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h300 || instr !== word(32'h300)) begin
      n_err++;
      $display("FAIL rr_instr: v=%b pc=%h instr=%h want 1 300 %h",
               instr_valid, instr_pc, instr, word(32'h300));
    end
  endtask

  task automatic test_redirect_accept();
    int r0;
    go_fetch();
    r0 = n_resp;
    lat = 2; imem_ready = 1; redirect = 1; redirect_pc = 32'h0000_0400;
    tick();
    redirect = 0;
    for (int i = 0; i < 10 && (m_out || m_hold); i++) begin
      n_chk++;
      if (instr_valid !== 1'b0 || imem_req !== 1'b0) begin
        n_err++;
        $display("FAIL ra_drop: v=%b req=%b want 0 0", instr_valid, imem_req);
      end
      tick();
    end
    n_chk++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h400 || n_resp - r0 != 1) begin
      n_err++;
      $display("FAIL ra_addr: req=%b addr=%h resp=%0d want 1 400 1",
               imem_req, imem_addr, n_resp - r0);
    end
    lat = 1;
    tick();
    imem_ready = 0;
    tick();
    n_chk++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h400 || instr !== word(32'h400)) begin
      n_err++;
      $display("FAIL ra_instr: v=%b pc=%h instr=%h want 1 400 %h",
               instr_valid, instr_pc, instr, word(32'h400));
    end
  endtask

  task automatic test_redirect_out();
    go_fetch();
    lat = 1; imem_ready = 1;
    tick();
    imem_ready = 0;
    tick();
    stall = 1;
    n_chk++;
    if (instr_valid !== 1'b1) begin
      n_err++;
      $display("FAIL ro_pre: v=%b want 1", instr_valid);
    end
    redirect = 1; redirect_pc = 32'h0000_0203;
    tick();
    redirect = 0;
    n_chk++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      n_err++;
      $display("FAIL ro_drop: v=%b req=%b addr=%h want 0 1 200",
               instr_valid, imem_req, imem_addr);
    end
    stall = 0; imem_ready = 1;
    tick();
    imem_ready = 0;
    tick();
    n_chk++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h200) begin
      n_err++;
      $display("FAIL ro_instr: v=%b pc=%h want 1 200", instr_valid, instr_pc);
    end
  endtask

  task automatic test_reset_wait();
    go_fetch();
    lat = 3; imem_ready = 1;
    tick();
    imem_ready = 0; rst_n = 0;
    tick();
    rst_n = 1;
    n_chk++;
    if (instr_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h0) begin
      n_err++;
      $display("FAIL rst_wait: v=%b req=%b addr=%h want 0 1 0",
               instr_valid, imem_req, imem_addr);
    end
    lat = 1; imem_ready = 1;
    tick();
    imem_ready = 0;
    tick();
    n_chk++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== word(32'h0)) begin
      n_err++;
      $display("FAIL rst_refetch: v=%b pc=%h instr=%h want 1 0 %h",
               instr_valid, instr_pc, instr, word(32'h0));
    end
  endtask

  task automatic test_wrap();
    go_fetch();
    n_chk++;
    if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
      n_err++;
      $display("FAIL wrap_first: req=%b addr=%h want 1 fffffffc", w_req, w_addr);
    end
    w_ready = 1;
    tick();
    w_ready = 0; w_rvalid = 1; w_rdata = word(32'hFFFF_FFFC);
    tick();
    w_rvalid = 0;
    n_chk++;
    if (w_valid !== 1'b1 || w_ipc !== 32'hFFFF_FFFC || w_instr !== word(32'hFFFF_FFFC)) begin
      n_err++;
      $display("FAIL wrap_instr: v=%b pc=%h instr=%h want 1 fffffffc %h",
               w_valid, w_ipc, w_instr, word(32'hFFFF_FFFC));
    end
    tick();
    n_chk++;
    if (w_req !== 1'b1 || w_addr !== 32'h0) begin
      n_err++;
      $display("FAIL wrap_next: req=%b addr=%h want 1 0", w_req, w_addr);
    end
  endtask

  task automatic test_random();
    logic er;
    for (int i = 0; i < 3000; i++) begin
      imem_ready  = ($urandom_range(0, 2) != 0);
      stall       = ($urandom_range(0, 2) == 0);
      redirect    = ($urandom_range(0, 7) == 0);
      redirect_pc = ($urandom_range(0, 3) == 0) ?
                    (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      lat         = $urandom_range(1, 3);
      tick();
      er = !m_out && !m_hold;
      n_chk++;
      if (imem_req !== er || (er && imem_addr !== m_pc) ||
          instr_valid !== m_hold ||
          (m_hold && (instr !== m_instr || instr_pc !== m_ipc))) begin
        n_err++;
        $display("FAIL rand[%0d]: req=%b addr=%h v=%b instr=%h pc=%h want %b %h %b %h %h",
                 i, imem_req, imem_addr, instr_valid, instr, instr_pc,
                 er, m_pc, m_hold, m_instr, m_ipc);
      end
    end
    redirect = 0; stall = 0; imem_ready = 0;
  endtask

  initial begin
    n_chk = 0; n_err = 0; n_resp = 0; lat = 1;
    rst_n = 0; imem_ready = 0; imem_rvalid = 0; imem_rdata = 0;
    redirect = 0; redirect_pc = 0; stall = 0;
    w_ready = 0; w_rvalid = 0; w_rdata = 0;
    w_red = 0; w_rpc = 0; w_stall = 0;
    mem_busy = 0; mem_addr = 0; mem_cnt = 0;
    m_pc = 0; m_out = 0; m_stale = 0; m_fa = 0;
    m_hold = 0; m_instr = NOP; m_ipc = 0;
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_rvalid();
    test_redirect_accept();
    test_redirect_out();
    test_reset_wait();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Owns the program counter and produces the 32-bit instruction word consumed by the control decoder and the datapath. It issues one outstanding read at a time to instruction memory over a req/ready + rvalid handshake. It holds the fetched word stable while downstream stalls, and discards in-flight fetches when a jump or branch redirect arrives.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (must be word aligned)
PC_STEP, 4, sequential PC increment in bytes

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
imem_req  output  1  read request to instruction memory
imem_addr  output  32  word-aligned fetch address, valid while imem_req=1
imem_ready  input  1  memory accepts request this cycle (imem_req & imem_ready = accept)
imem_rvalid  input  1  read data valid, earliest one cycle after accept
imem_rdata  input  32  instruction word returned
redirect  input  1  taken jump/branch from execute, single-cycle pulse
redirect_pc  input  32  target PC, sampled when redirect=1
stall  input  1  downstream cannot consume instr this cycle
instr_valid  output  1  instr/instr_pc hold a live instruction
instr  output  32  fetched instruction word (to control/decoder)
instr_pc  output  32  PC of instr (for branch/JAL target and link calc)

Behaviour:
- Reset (rst_n=0 at clk edge): state=FETCH, pc=RESET_PC, instr_valid=0, instr=32'h0000_0013 (NOP), instr_pc=RESET_PC. imem_req is combinational: 1 in FETCH only. imem_addr=pc.
- States: FETCH, WAIT, OUT, DROP. At most one request outstanding.
- FETCH: imem_req=1. On accept: go WAIT. No accept: stay, request held with same address.
- WAIT: imem_req=0. On imem_rvalid: instr<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+PC_STEP (mod 2^32, wraps 0xFFFF_FFFC->0), go OUT.
- OUT: imem_req=0. If stall=0: instr_valid<=0, go FETCH (instruction consumed this cycle). If stall=1: instr, instr_pc, instr_valid unchanged.
- DROP: waiting on a stale response. On imem_rvalid: data discarded, go FETCH. instr_valid stays 0.
- Redirect (highest priority, any state). New target is redirect_pc with bits [1:0] forced to 0.
  - FETCH, no accept: pc<=target, stay FETCH. The address change while req is pending is permitted.
  - FETCH, accept same cycle: pc<=target, go DROP.
  - WAIT, no rvalid: pc<=target, go DROP.
  - WAIT with rvalid same cycle: data discarded, pc<=target, go FETCH.
  - OUT: instr_valid<=0 regardless of stall, pc<=target, go FETCH.
  - DROP: pc<=target, stay DROP, or go FETCH if rvalid arrives the same cycle.
- Latency: accept to instr_valid is (rvalid cycle + 1). Redirect to imem_req at the new target is 1 cycle from FETCH/OUT, or after the stale rvalid from WAIT/DROP.
- imem_rvalid in FETCH or OUT is a protocol error. It is ignored, with no state change.
- Reset mid-operation: any outstanding response after reset is not tracked. Memory must also be reset.

Test Plan:
- Reset then sequential fetch, ready=1 and rvalid 1 cycle after accept, rdata=PC-tagged words → imem_addr 0x0,0x4,0x8…; instr_pc matches; one instr_valid pulse per fetch; state sequence FETCH→WAIT→OUT→FETCH.
- Backpressure: imem_ready low 3 cycles, then stall high 4 cycles in OUT → imem_addr stable while waiting; instr/instr_pc/instr_valid held unchanged; next fetch issues only after stall drops.
- Redirect in WAIT to 0x0000_0104 (JAL) before rvalid → stale word never appears on instr. Next imem_addr=0x104, instr_pc=0x104.
- Redirect coincident with rvalid in WAIT, and coincident with accept in FETCH → stale data dropped in both cases. The second case passes through DROP, and exactly one response is consumed.
- Redirect in OUT while stall=1, target 0x0000_0203 → instr_valid drops next cycle; fetch at 0x200 (low bits masked).
- PC wrap: RESET_PC=0xFFFF_FFFC → second fetch address 0x0000_0000. Also assert rst_n=0 during WAIT → instr_valid=0, pc=RESET_PC next cycle.
